// File: rtl/trace_cmd_sequencer.sv
// Trace command sequencer: accepts decoded trace records one at a time,
// issues cache accesses over a req/ack handshake, runs the clear sweep
// across every cache set and streams the read/write/hit/miss counters.
module trace_cmd_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 14,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_code,
  input  logic [ADDR_W-1:0]     cmd_addr,
  output logic                  cache_req,
  output logic [1:0]            cache_op,
  output logic [ADDR_W-1:0]     cache_addr,
  output logic                  cache_clr,
  output logic [INDEX_BITS-1:0] cache_idx,
  input  logic                  cache_ack,
  input  logic                  cache_hit,
  output logic                  stat_valid,
  output logic [1:0]            stat_sel,
  output logic [CNT_W-1:0]      stat_data,
  input  logic                  stat_ready,
  output logic                  busy,
  output logic                  bad_cmd
);

  typedef enum logic [1:0] {IDLE, ISSUE, CLEAR, PRINT} state_t;

  localparam logic [INDEX_BITS-1:0] IDX_LAST = '1;
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

  // Counter slots line up with stat_sel: 0=reads, 1=writes, 2=hits, 3=misses.
  localparam int C_RD = 0;
  localparam int C_WR = 1;
  localparam int C_HT = 2;
  localparam int C_MS = 3;

  state_t           state;
  logic [CNT_W-1:0] cnt [4];
  logic             accept;
  logic [1:0]       next_sel;

  assign accept   = cmd_valid && cmd_ready;
  assign next_sel = stat_sel + 2'd1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Sequencer FSM; every output is registered and updated alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      cache_req  <= 1'b0;
      cache_op   <= '0;
      cache_addr <= '0;
      cache_clr  <= 1'b0;
      cache_idx  <= '0;
      stat_valid <= 1'b0;
      stat_sel   <= '0;
      stat_data  <= '0;
      busy       <= 1'b0;
      bad_cmd    <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      bad_cmd <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            if (cmd_code[3:2] == 2'b00) begin
              state      <= ISSUE;
              cmd_ready  <= 1'b0;
              busy       <= 1'b1;
              cache_req  <= 1'b1;
              cache_op   <= cmd_code[1:0];
              cache_addr <= cmd_addr;
            end else if (cmd_code == 4'd8) begin
              state     <= CLEAR;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              cache_clr <= 1'b1;
              cache_idx <= '0;
            end else if (cmd_code == 4'd9) begin
              state      <= PRINT;
              cmd_ready  <= 1'b0;
              busy       <= 1'b1;
              stat_valid <= 1'b1;
              stat_sel   <= '0;
              stat_data  <= cnt[C_RD];
            end else begin
              // Unsupported code: flag it and drop the record.
              bad_cmd <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cache_ack) begin
            state     <= IDLE;
            cache_req <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            // Invalidate (op 3) is not an access and is not counted.
            if (cache_op != 2'd3) begin
              if (cache_op == 2'd1) cnt[C_WR] <= sat_inc(cnt[C_WR]);
              else                  cnt[C_RD] <= sat_inc(cnt[C_RD]);
              if (cache_hit) cnt[C_HT] <= sat_inc(cnt[C_HT]);
              else           cnt[C_MS] <= sat_inc(cnt[C_MS]);
            end
          end
        end
        CLEAR: begin
          if (cache_ack) begin
            if (cache_idx == IDX_LAST) begin
              state     <= IDLE;
              cache_clr <= 1'b0;
              cache_idx <= '0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              for (int i = 0; i < 4; i++) cnt[i] <= '0;
            end else begin
              cache_idx <= cache_idx + 1'b1;
            end
          end
        end
        PRINT: begin
          // Counters cannot move here, so stat_data only changes on handshake.
          if (stat_ready) begin
            if (stat_sel == 2'd3) begin
              state      <= IDLE;
              stat_valid <= 1'b0;
              stat_sel   <= '0;
              stat_data  <= '0;
              cmd_ready  <= 1'b1;
              busy       <= 1'b0;
            end else begin
              stat_sel  <= next_sel;
              stat_data <= cnt[next_sel];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/trace_cmd_sequencer.md
Name: trace_cmd_sequencer

Overview:
- Sequences decoded trace records (command code + address) into the cache model, one operation at a time, over a req/ack handshake.
- Handles two non-access commands itself: clear (8) sweeps every cache set, and print (9) streams the statistics counters.
- Sits between the trace front end, which feeds the record stream, and the cache, and keeps the read/write/hit/miss counters.

Parameters:
- ADDR_W, 32, trace address width.
- INDEX_BITS, 14, cache set index width; the clear sweep covers 2^INDEX_BITS sets.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  trace record valid.
- cmd_ready  out  1  record accepted when cmd_valid && cmd_ready.
- cmd_code  in  4  trace command code.
- cmd_addr  in  ADDR_W  trace address; ignored for codes 8 and 9.
- cache_req  out  1  cache operation request.
- cache_op  out  2  0=data read, 1=data write, 2=instr fetch, 3=invalidate.
- cache_addr  out  ADDR_W  operation address.
- cache_clr  out  1  clear-set request; replaces cache_req during a sweep.
- cache_idx  out  INDEX_BITS  set being cleared.
- cache_ack  in  1  completes the pending cache_req or cache_clr in the same cycle.
- cache_hit  in  1  hit/miss result, valid with cache_ack for ops 0-2.
- stat_valid  out  1  statistics word valid.
- stat_sel  out  2  0=reads, 1=writes, 2=hits, 3=misses.
- stat_data  out  CNT_W  counter value.
- stat_ready  in  1  statistics word consumed.
- busy  out  1  high in any state other than IDLE.
- bad_cmd  out  1  one-cycle pulse when an unsupported code is accepted.

Behaviour:
- Reset (asynchronous, any state, including mid-sweep or mid-print):
  - state=IDLE, all counters=0.
  - Outputs: cmd_ready=0, cache_req=0, cache_clr=0, cache_op=0, cache_addr=0, cache_idx=0, stat_valid=0, stat_sel=0, stat_data=0, busy=0, bad_cmd=0.
  - First cycle after rst_n deasserts: cmd_ready=1.
- States: IDLE, ISSUE, CLEAR, PRINT.
- IDLE:
  - cmd_ready=1.
  - On accept, registered decode:
    - codes 0-3: latch op/addr, go to ISSUE.
    - code 8: cache_idx=0, go to CLEAR.
    - code 9: stat_sel=0, go to PRINT.
    - any other code: bad_cmd=1 for the next cycle, stay IDLE, record dropped.
- ISSUE:
  - cache_req=1; cache_op and cache_addr held stable until cache_ack.
  - On cache_ack, go to IDLE; cache_req drops the next cycle.
  - Minimum cost is 2 cycles per record (accept, then req with immediate ack).
- Counters, updated on cache_ack in ISSUE:
  - ops 0 and 2: reads+1.
  - op 1: writes+1.
  - ops 0-2: hits+1 if cache_hit, else misses+1.
  - op 3: no counter changes.
  - All counters saturate at 2^CNT_W-1; no wrap.
- CLEAR:
  - cache_clr=1 with cache_idx.
  - Each cache_ack: if cache_idx==2^INDEX_BITS-1, then zero all counters, set cache_idx=0, go to IDLE; else cache_idx+1.
  - No wrap past the last set. Sweep length is exactly 2^INDEX_BITS acks.
- PRINT:
  - stat_valid=1, with stat_data = the counter selected by stat_sel.
  - Each stat_valid && stat_ready: if stat_sel==3, go to IDLE; else stat_sel+1.
  - stat_data stays stable while stat_ready=0.
  - Exactly 4 words in fixed order: reads, writes, hits, misses.
- cmd_ready=0 in ISSUE, CLEAR and PRINT; records are never lost or reordered.
- cache_ack outside ISSUE/CLEAR is ignored and changes no counter.
- cache_req and cache_clr are never both high.
- busy = (state != IDLE).

Test Plan:
- Reset release, then cmd {0,0x0000_1000} with ack+hit 1 cycle after req -> cache_req for exactly 1 cycle, op=0, addr=0x1000; reads=1, hits=1; cmd_ready back high 2 cycles after accept.
- Cmds {1,0x20} miss, {2,0x40} hit, {3,0x80} hit, each acked after 3 wait cycles -> req held 4 cycles with addr stable; reads=1, writes=1, hits=1, misses=1.
- INDEX_BITS=2, cmd 8 with ack every cycle -> cache_idx 0,1,2,3 over 4 cycles, then IDLE; all counters 0; stalling ack for 2 cycles at idx=2 holds idx=2.
- Cmd 9 after the second scenario, stat_ready low for 3 cycles then high -> words (0,1),(1,1),(2,1),(3,1) in order; stat_data stable during the stall; IDLE afterwards.
- Cmd code 5 -> bad_cmd for 1 cycle, no cache_req, counters unchanged; the next valid record is accepted in the following cycle.
- rst_n low at sweep idx=1 and again mid-PRINT at stat_sel=2 -> all outputs 0 immediately and counters 0; the next record is accepted normally.
